load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
// - Core-side front end of the unified 32-bit data memory. Sits directly upstream of the memory
//   block and drives its address, data_in, we and byte_enable inputs from its own mem_* ports.
// - Takes byte/half/word load and store requests through a valid/ready handshake.
// - Generates byte enables and lane-shifted store data. Extracts and sign/zero-extends load data.
// - Returns one response per request through a valid/ready handshake.
// PARAMETERS
// - MEM_BYTES  4096  size of the addressable window. Any byte touched at or above it is an error.
// PORTS
// - clk             in   1   clock, rising edge
// - reset           in   1   asynchronous, active-high reset
// - req_valid       in   1   request present
// - req_ready       out  1   request accepted when req_valid && req_ready at a rising edge
// - req_we          in   1   1=store, 0=load
// - req_addr        in   32  byte address
// - req_wdata       in   32  store data, right-aligned
// - req_size        in   2   00=byte, 01=half, 10=word, 11=illegal
// - req_unsigned    in   1   loads only: zero-extend (1) or sign-extend (0)
// - rsp_valid       out  1   response present, held until rsp_ready
// - rsp_ready       in   1   response consumed when rsp_valid && rsp_ready at a rising edge
// - rsp_rdata       out  32  extended load data; 0 for stores and errors
// - rsp_err         out  1   request was illegal, out of window, or misaligned-and-unsupported
// - mem_address     out  32  word-aligned address to the memory
// - mem_wdata       out  32  lane-shifted store data to the memory
// - mem_rdata       in   32  combinational read data from the memory (same cycle as mem_address)
// - mem_we          out  1   memory write strobe; the write commits at the next rising edge
// - mem_byte_enable out  4   bit i enables byte lane i
// BEHAVIOUR
// - FSM states: IDLE, ACC0, ACC1, RESP. Reset (async) forces IDLE and clears all request/response
//   registers.
// - Reset values:
//   - req_ready=0 while reset is asserted; 1 in IDLE afterwards.
//   - rsp_valid=0, rsp_rdata=0, rsp_err=0.
//   - mem_we=0, mem_byte_enable=0, mem_address=0, mem_wdata=0.
// - Transitions:
//   - IDLE: req_ready=1. On accept, register the request. Go to ACC0 if legal, otherwise RESP
//     with err=1.
//   - ACC0: drive word0 = addr & ~3. Capture mem_rdata. Go to ACC1 if the access crosses a
//     word boundary, otherwise RESP.
//   - ACC1: drive word0+4. Capture mem_rdata. Go to RESP.
//   - RESP: rsp_valid=1. Go to IDLE on rsp_ready. There is no new accept in the same cycle, so
//     throughput is at most one request per 3 cycles.
// - Latency: accepted at edge N -> rsp_valid rises at N+2 (single access) or N+3 (split access);
//   errors at N+1.
// - Outside ACC0/ACC1: mem_we=0 and mem_byte_enable=0. mem_we = stored req_we in ACC0/ACC1 only.
// - Lane rules (off = addr[1:0], m = size mask 4'b0001, 4'b0011 or 4'b1111):
//   - ACC0: byte_enable = (m << off)[3:0]; wdata = req_wdata << 8*off.
//   - ACC1: byte_enable = (m << off)[7:4]; wdata = req_wdata >> 8*(4-off).
// - Load data: ({rd1,rd0} >> 8*off) is truncated to the size, then extended per req_unsigned.
// - Errors: size=11, any touched byte >= MEM_BYTES, or misalignment without the split feature.
//   Errors never assert mem_we.
// - Reset mid-operation (ACC0/ACC1/RESP): mem_we drops immediately and the request is dropped
//   with no response. A store whose commit edge is not reached is not written; a word0 already
//   written by ACC0 stays written.
// - Inputs are ignored outside IDLE. req_* need only be stable at the accept edge.
// CONFIGURATION
// - LSU_MISALIGNED_SPLIT_EN defined: an access crossing a word boundary (half at off=3, word at
//   off!=0) is performed as two aligned accesses (ACC0 then ACC1).
// - LSU_MISALIGNED_SPLIT_EN undefined:
//   - Half with addr[0]=1, or word with addr[1:0]!=0, is an error (rsp_err=1, no memory access).
//   - ACC1 is unreachable.
// TESTING
// - Store word 0xDEADBEEF @0x800, then load word @0x800 -> mem_we one cycle with be=1111;
//   rsp_rdata=0xDEADBEEF at N+2.
// - Store byte 0xA5 @0x803, then load byte signed / unsigned @0x803 -> be=1000, wdata=0xA5000000;
//   rdata=0xFFFFFFA5 / 0x000000A5.
// - Store half 0x8001 @0x806, then load half signed -> be=1100; rdata=0xFFFF8001;
//   bytes @0x804..0x805 unchanged.
// - Split on: store word 0x11223344 @0x801 -> ACC0 be=1110 wdata=0x22334400 @0x800;
//   ACC1 be=0001 wdata=0x00000011 @0x804; load back =0x11223344 at N+3.
//   Split off: same store -> rsp_err=1 at N+1, mem_we never high.
// - Load word @MEM_BYTES-4 ok. Word @MEM_BYTES-2 (split on) -> err. size=11 -> err, rdata=0.
// - Hold rsp_ready=0 for 5 cycles -> rsp_valid and data stable, req_ready=0. Assert reset in ACC0
//   of a store -> mem_we falls at once, no response, req_ready=1 after release.

Source files
------------

// File: rtl/load_store_unit.sv
// Core-side load/store front end for a unified 32-bit data memory: lane steering, byte enables, load extension.
// Optional feature macro LSU_MISALIGNED_SPLIT_EN: word-crossing accesses become two aligned memory accesses.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_we,
  output logic [3:0]  mem_byte_enable
);

`ifdef LSU_MISALIGNED_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, ACC0 = 2'd1, ACC1 = 2'd2, RESP = 2'd3} state_t;

  state_t      state_reg, state_next;
  logic [31:0] addr_reg, wdata_reg, rd0_reg, rd1_reg;
  logic [1:0]  size_reg;
  logic [3:0]  mask_reg;
  logic        we_reg, unsigned_reg, err_reg;

  // Request decode, evaluated only at the accept edge
  logic [3:0]  req_mask;
  logic [1:0]  req_last_off;
  logic [32:0] req_last;
  logic        req_misaligned, req_err;

  always_comb begin
    req_mask     = 4'b1111;
    req_last_off = 2'd3;
    case (req_size)
      2'b00:   begin req_mask = 4'b0001; req_last_off = 2'd0; end
      2'b01:   begin req_mask = 4'b0011; req_last_off = 2'd1; end
      default: begin req_mask = 4'b1111; req_last_off = 2'd3; end
    endcase
    req_last       = {1'b0, req_addr} + {31'd0, req_last_off};
    req_misaligned = (req_size == 2'b01 && req_addr[0]) ||
                     (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    req_err        = (req_size == 2'b11) || (req_last >= 33'(MEM_BYTES)) ||
                     (!SPLIT_EN && req_misaligned);
  end

  // Lane geometry of the stored request; lanes[7:4] are the bytes spilling into word0+4
  logic [1:0]  off;
  logic [7:0]  lanes;
  logic        crossing;
  logic [4:0]  sh_lo;
  logic [5:0]  sh_hi;
  logic [31:0] word0;

  assign off      = addr_reg[1:0];
  assign lanes    = {4'b0000, mask_reg} << off;
  assign crossing = SPLIT_EN && (lanes[7:4] != 4'b0000);
  assign sh_lo    = {off, 3'b000};
  assign sh_hi    = 6'd32 - {1'b0, off, 3'b000};
  assign word0    = {addr_reg[31:2], 2'b00};

  logic [63:0] rd_pair;
  logic [31:0] rd_aligned, load_data;

  assign rd_pair    = {rd1_reg, rd0_reg};
  assign rd_aligned = rd_pair[sh_lo +: 32];

  always_comb begin
    load_data = rd_aligned;
    case (size_reg)
      2'b00:   load_data = {{24{!unsigned_reg && rd_aligned[7]}}, rd_aligned[7:0]};
      2'b01:   load_data = {{16{!unsigned_reg && rd_aligned[15]}}, rd_aligned[15:0]};
      default: load_data = rd_aligned;
    endcase
  end

  always_comb begin
    state_next      = state_reg;
    req_ready       = 1'b0;
    rsp_valid       = 1'b0;
    rsp_rdata       = 32'd0;
    rsp_err         = 1'b0;
    mem_address     = 32'd0;
    mem_wdata       = 32'd0;
    mem_we          = 1'b0;
    mem_byte_enable = 4'b0000;
    case (state_reg)
      IDLE: begin
        req_ready = !reset;
        if (req_valid && !reset) state_next = req_err ? RESP : ACC0;
      end
      ACC0: begin
        mem_address     = word0;
        mem_wdata       = wdata_reg << sh_lo;
        mem_we          = we_reg;
        mem_byte_enable = lanes[3:0];
        state_next      = crossing ? ACC1 : RESP;
      end
      ACC1: begin
        mem_address     = word0 + 32'd4;
        mem_wdata       = wdata_reg >> sh_hi;
        mem_we          = we_reg;
        mem_byte_enable = lanes[7:4];
        state_next      = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_reg;
        rsp_rdata = (err_reg || we_reg) ? 32'd0 : load_data;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      addr_reg     <= 32'd0;
      wdata_reg    <= 32'd0;
      rd0_reg      <= 32'd0;
      rd1_reg      <= 32'd0;
      size_reg     <= 2'b00;
      mask_reg     <= 4'b0000;
      we_reg       <= 1'b0;
      unsigned_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: if (req_valid) begin
          addr_reg     <= req_addr;
          wdata_reg    <= req_wdata;
          size_reg     <= req_size;
          mask_reg     <= req_mask;
          we_reg       <= req_we;
          unsigned_reg <= req_unsigned;
          err_reg      <= req_err;
          rd0_reg      <= 32'd0;
          rd1_reg      <= 32'd0;
        end
        ACC0:    rd0_reg <= mem_rdata;
        ACC1:    rd1_reg <= mem_rdata;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table with a response scoreboard, a behavioural
// byte-enabled memory, and hand-written sequences for backpressure and reset during a store.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_address, mem_wdata, mem_rdata;
  logic        mem_we;
  logic [3:0]  mem_byte_enable;

  load_store_unit #(.MEM_BYTES(4096)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_byte_enable(mem_byte_enable)
  );

  always #5 clk = ~clk;

  // Memory model: word i preloaded with 0xC0DE0000|i, byte-enabled write at the rising edge
  logic [31:0] tb_mem [0:1023];
  logic        mem_init;
  assign mem_rdata = tb_mem[mem_address[11:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) tb_mem[i] <= 32'hC0DE0000 | 32'(i);
    end else if (mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_byte_enable[b]) tb_mem[mem_address[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_wecyc;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic [31:0] exp_maddr;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(logic we, logic [31:0] addr, logic [31:0] wdata, logic [1:0] size,
                              logic uns, logic [31:0] rdata, logic err, int lat, int wecyc,
                              logic [3:0] be, logic [31:0] wd, logic [31:0] maddr);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.size = size; v.uns = uns;
    v.exp_rdata = rdata; v.exp_err = err; v.exp_lat = lat; v.exp_wecyc = wecyc;
    v.exp_be = be; v.exp_wd = wd; v.exp_maddr = maddr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_req(input vec_t v);
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
    req_size = v.size; req_unsigned = v.uns;
    sb.push_back(v);
  endtask

  task automatic scramble_req();
    req_valid = 1'b0; req_we = 1'($urandom()); req_addr = $urandom();
    req_wdata = $urandom(); req_size = 2'($urandom()); req_unsigned = 1'($urandom());
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    vec_t       e;
    int         lat, wec;
    logic [3:0] be1;
    logic [31:0] wd1, ad1;
    bit         seen;
    @(negedge clk);
    check($sformatf("v%0d req_ready", idx), 32'(req_ready), 32'd1);
    drive_req(v);
    @(posedge clk);
    #1 scramble_req();
    lat = 0; wec = 0; be1 = 4'b0; wd1 = 32'd0; ad1 = 32'd0; seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      lat++;
      if (mem_we) wec++;
      if (!seen && mem_byte_enable != 4'b0000) begin
        seen = 1'b1; be1 = mem_byte_enable; wd1 = mem_wdata; ad1 = mem_address;
      end
      if (rsp_valid) break;
    end
    check($sformatf("v%0d rsp_valid", idx), 32'(rsp_valid), 32'd1);
    e = sb.pop_front();
    check($sformatf("v%0d rdata", idx), rsp_rdata, e.exp_rdata);
    check($sformatf("v%0d err", idx), 32'(rsp_err), 32'(e.exp_err));
    check($sformatf("v%0d latency", idx), 32'(lat), 32'(e.exp_lat));
    check($sformatf("v%0d we_cycles", idx), 32'(wec), 32'(e.exp_wecyc));
    check($sformatf("v%0d be", idx), 32'(be1), 32'(e.exp_be));
    check($sformatf("v%0d mem_wdata", idx), wd1, e.exp_wd);
    check($sformatf("v%0d mem_address", idx), ad1, e.exp_maddr);
    $display("txn %0d: we=%0d addr=%h size=%0d uns=%0d -> rdata=%h err=%0d lat=%0d be=%b",
             idx, v.we, v.addr, v.size, v.uns, rsp_rdata, rsp_err, lat, be1);
    @(posedge clk);
  endtask

  initial begin
    vec_t v;
    logic [31:0] held;
    reset = 1'b1; mem_init = 1'b1; rsp_ready = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    req_size = 2'b00; req_unsigned = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset req_ready", 32'(req_ready), 32'd0);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_rdata", rsp_rdata, 32'd0);
    check("reset rsp_err", 32'(rsp_err), 32'd0);
    check("reset mem_we", 32'(mem_we), 32'd0);
    check("reset mem_be", 32'(mem_byte_enable), 32'd0);
    check("reset mem_address", mem_address, 32'd0);
    check("reset mem_wdata", mem_wdata, 32'd0);
    reset = 1'b0; mem_init = 1'b0;

    //            we  addr        wdata         sz     u  rdata         err lat wec be       wd            maddr
    vecs.push_back(mk(1, 32'h800, 32'hDEADBEEF, 2'b10, 0, 32'h0,        0, 2, 1, 4'b1111, 32'hDEADBEEF, 32'h800));
    vecs.push_back(mk(0, 32'h800, 32'h0,        2'b10, 0, 32'hDEADBEEF, 0, 2, 0, 4'b1111, 32'h0,        32'h800));
    vecs.push_back(mk(1, 32'h803, 32'h123456A5, 2'b00, 0, 32'h0,        0, 2, 1, 4'b1000, 32'hA5000000, 32'h800));
    vecs.push_back(mk(0, 32'h803, 32'h0,        2'b00, 0, 32'hFFFFFFA5, 0, 2, 0, 4'b1000, 32'h0,        32'h800));
    vecs.push_back(mk(0, 32'h803, 32'h0,        2'b00, 1, 32'h000000A5, 0, 2, 0, 4'b1000, 32'h0,        32'h800));
    vecs.push_back(mk(1, 32'h806, 32'h5A5A8001, 2'b01, 0, 32'h0,        0, 2, 1, 4'b1100, 32'h80010000, 32'h804));
    vecs.push_back(mk(0, 32'h806, 32'h0,        2'b01, 0, 32'hFFFF8001, 0, 2, 0, 4'b1100, 32'h0,        32'h804));
    vecs.push_back(mk(0, 32'h804, 32'h0,        2'b10, 0, 32'h80010201, 0, 2, 0, 4'b1111, 32'h0,        32'h804));
`ifdef LSU_MISALIGNED_SPLIT_EN
    vecs.push_back(mk(1, 32'h801, 32'h11223344, 2'b10, 0, 32'h0,        0, 3, 2, 4'b1110, 32'h22334400, 32'h800));
    vecs.push_back(mk(0, 32'h801, 32'h0,        2'b10, 0, 32'h11223344, 0, 3, 0, 4'b1110, 32'h0,        32'h800));
`else
    vecs.push_back(mk(1, 32'h801, 32'h11223344, 2'b10, 0, 32'h0,        1, 1, 0, 4'b0000, 32'h0,        32'h0));
    vecs.push_back(mk(0, 32'h801, 32'h0,        2'b10, 0, 32'h0,        1, 1, 0, 4'b0000, 32'h0,        32'h0));
`endif
    vecs.push_back(mk(0, 32'hFFC, 32'h0,        2'b10, 0, 32'hC0DE03FF, 0, 2, 0, 4'b1111, 32'h0,        32'hFFC));
    vecs.push_back(mk(0, 32'hFFE, 32'h0,        2'b10, 0, 32'h0,        1, 1, 0, 4'b0000, 32'h0,        32'h0));
    vecs.push_back(mk(0, 32'hFFE, 32'h0,        2'b01, 1, 32'h0000C0DE, 0, 2, 0, 4'b1100, 32'h0,        32'hFFC));
    vecs.push_back(mk(0, 32'h1000, 32'h0,       2'b00, 0, 32'h0,        1, 1, 0, 4'b0000, 32'h0,        32'h0));
    vecs.push_back(mk(1, 32'h1000, 32'hFFFFFFFF, 2'b10, 0, 32'h0,       1, 1, 0, 4'b0000, 32'h0,        32'h0));
    vecs.push_back(mk(0, 32'h800, 32'h0,        2'b11, 0, 32'h0,        1, 1, 0, 4'b0000, 32'h0,        32'h0));
    vecs.push_back(mk(1, 32'h800, 32'h0,        2'b11, 0, 32'h0,        1, 1, 0, 4'b0000, 32'h0,        32'h0));

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Backpressure: response held for 5 cycles while a competing request is ignored
    @(negedge clk);
    rsp_ready = 1'b0;
    drive_req(mk(0, 32'hFFC, 32'h0, 2'b10, 0, 32'hC0DE03FF, 0, 2, 0, 4'b1111, 32'h0, 32'hFFC));
    @(posedge clk);
    #1 req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h800; req_size = 2'b10; req_wdata = 32'h0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    check("hold rsp_valid rise", 32'(rsp_valid), 32'd1);
    held = rsp_rdata;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("hold%0d rsp_valid", c), 32'(rsp_valid), 32'd1);
      check($sformatf("hold%0d rdata", c), rsp_rdata, held);
      check($sformatf("hold%0d req_ready", c), 32'(req_ready), 32'd0);
      check($sformatf("hold%0d mem_we", c), 32'(mem_we), 32'd0);
    end
    v = sb.pop_front();
    check("hold rdata", rsp_rdata, v.exp_rdata);
    check("hold err", 32'(rsp_err), 32'(v.exp_err));
    $display("txn hold: addr=%h -> rdata=%h err=%0d after 5 stalled cycles", v.addr, rsp_rdata, rsp_err);
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("hold release rsp_valid", 32'(rsp_valid), 32'd0);
    check("hold release req_ready", 32'(req_ready), 32'd1);

    // Reset in ACC0 of a store: write must not commit, no response
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h808; req_wdata = 32'hCAFEF00D;
    req_size = 2'b10; req_unsigned = 1'b0;
    @(posedge clk);
    #1 scramble_req();
    check("rst acc0 mem_we", 32'(mem_we), 32'd1);
    #1 reset = 1'b1;
    #1 check("rst mem_we drop", 32'(mem_we), 32'd0);
    check("rst mem_be drop", 32'(mem_byte_enable), 32'd0);
    check("rst req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("rst no_rsp%0d", c), 32'(rsp_valid), 32'd0);
    end
    check("rst req_ready after", 32'(req_ready), 32'd1);
    $display("txn reset: store 0xCAFEF00D @808 aborted in ACC0");
    run_vec(mk(0, 32'h808, 32'h0, 2'b10, 0, 32'hC0DE0202, 0, 2, 0, 4'b1111, 32'h0, 32'h808), 99);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
